rgb_color_decoder: RTL
======================

Name: rgb_color_decoder

Overview:
- Reverse direction of the 3-bit colour → 24-bit RGB converter.
- Takes a stream of 24-bit RGB pixels and quantises each to the 3-bit colour code, {R,G,B} bit order, matching the encoder's mapping (3'b100 ↔ 24'hFF0000).
- Two-stage pipeline with valid/ready handshakes on both sides.
- Flags pixels that are not exact primaries and counts them, for display-path loopback checking.

Parameters:
- THRESH, 8'h80: per-channel threshold. A channel value ≥ THRESH quantises to 1.
- CNT_W, 16: width of the mismatch counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- enable  input  1  accept new pixels when high; the pipeline still drains when low
- in_valid  input  1  rgb holds a valid pixel
- in_ready  output  1  decoder accepts rgb this cycle
- rgb  input  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B
- out_valid  output  1  color/exact valid
- out_ready  input  1  downstream accepts output
- color  output  3  {R≥THRESH, G≥THRESH, B≥THRESH}
- exact  output  1  every channel was 8'h00 or 8'hFF
- mismatch_cnt  output  CNT_W  count of accepted outputs with exact=0

Behaviour:
- Reset (rst high at a clk edge): out_valid=0, color=0, exact=0, mismatch_cnt=0, internal stage-1 valid=0.
  - in_ready is combinational and is 0 while rst is high.
  - Reset mid-stream discards all in-flight pixels. No output handshake completes in the reset cycle.
- Stall condition: stall = out_valid && !out_ready.
- Input side:
  - in_ready = enable && !stall && !rst.
  - A transfer occurs when in_valid && in_ready.
- Stage 1, when !stall:
  - s1_valid <= (in_valid && in_ready).
  - s1_rgb <= rgb.
  - When stalled, stage 1 holds.
- Stage 2 / output, when !stall:
  - out_valid <= s1_valid.
  - color and exact are computed from s1_rgb and registered.
  - When stalled, all outputs hold stable. color/exact must not change while out_valid=1 and out_ready=0.
- Latency:
  - Input transfer at edge N → out_valid=1 after edge N+1, i.e. 2 cycles, with out_ready held high.
  - Throughput is 1 pixel/cycle.
- Comparison: unsigned 8-bit, channel ≥ THRESH. Boundary: value == THRESH gives 1; value == THRESH-1 gives 0.
- exact: 1 iff R∈{00,FF}, G∈{00,FF} and B∈{00,FF}.
- mismatch_cnt:
  - Increments by 1 on each output handshake (out_valid && out_ready) with exact=0.
  - Saturates at all-ones; no wrap.
  - Not cleared by enable.
- enable falling mid-stream: no new accepts; in-flight pixels still emerge. enable rising resumes with no bubble beyond the pipeline depth.
- Simultaneous output handshake and input accept in the same cycle is allowed (full throughput).
- Bubbles: out_valid=0 cycles do not stall the pipeline; downstream readiness is ignored when out_valid=0.

Optional Feature:
- Macro RGB_DEC_STATS_EN.
- Defined: mismatch_cnt is implemented as above.
- Undefined: the counter logic is omitted and mismatch_cnt is driven constant 0. exact is still produced.

Test Plan:
1. Reset then sweep: enable=1, out_ready=1; drive the 8 primaries 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF back-to-back → color = 0..7 in order, exact=1 each, first out_valid exactly 2 cycles after the first accept, mismatch_cnt=0.
2. Threshold boundary: rgb=807F80 → color=3'b101, exact=0; rgb=7F807F → color=3'b010, exact=0; mismatch_cnt=2.
3. Backpressure: stream 4 pixels, hold out_ready=0 for 5 cycles mid-stream → in_ready=0 while stalled, color/exact held stable, all 4 outputs delivered in order with none lost or duplicated.
4. Enable gating: enable=0 with in_valid=1, rgb=FF0000 → in_ready=0, out_valid stays 0. enable=1 → color=3'b100 two cycles after the accept.
5. Reset mid-operation: 2 pixels in flight, pulse rst for 1 cycle → out_valid=0, mismatch_cnt=0 the next cycle; the dropped pixels never appear.
6. Saturation (CNT_W=2, RGB_DEC_STATS_EN defined): 5 non-exact pixels (e.g. 123456) → mismatch_cnt ends at 3. With the macro undefined → mismatch_cnt stays 0.

Source files
------------

// File: rtl/rgb_color_decoder_if.sv
// Stream bundle for rgb_color_decoder: pixel input handshake and colour output handshake.
// The decoder takes the slave view; the producer/consumer side takes the master view.
interface rgb_color_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] rgb;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  color;
  logic        exact;

  modport slave (
    input  in_valid, rgb, out_ready,
    output in_ready, out_valid, color, exact
  );

  modport master (
    output in_valid, rgb, out_ready,
    input  in_ready, out_valid, color, exact
  );
endinterface

// File: rtl/rgb_color_decoder.sv
// Two-stage 24-bit RGB -> 3-bit {R,G,B} colour quantiser with valid/ready on both sides.
// Define RGB_DEC_STATS_EN to build the saturating non-exact pixel counter (mismatch_cnt).
module rgb_color_decoder #(
  parameter logic [7:0]  THRESH = 8'h80,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  rgb_color_decoder_if.slave bus,
  output logic [CNT_W-1:0] mismatch_cnt
);

  logic        stall;
  logic        accept;
  logic        s1_valid;
  logic [23:0] s1_rgb;
  logic [2:0]  s1_color;
  logic        s1_exact;
  logic        out_valid_q;
  logic [2:0]  color_q;
  logic        exact_q;

  // A held output blocks both stages; a bubble (out_valid=0) never stalls.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = enable & ~stall & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;

  assign s1_color = {s1_rgb[23:16] >= THRESH,
                     s1_rgb[15:8]  >= THRESH,
                     s1_rgb[7:0]   >= THRESH};

  assign s1_exact = ((s1_rgb[23:16] == 8'h00) | (s1_rgb[23:16] == 8'hFF)) &
                    ((s1_rgb[15:8]  == 8'h00) | (s1_rgb[15:8]  == 8'hFF)) &
                    ((s1_rgb[7:0]   == 8'h00) | (s1_rgb[7:0]   == 8'hFF));

  // NOTE: the pixel data register has no reset; s1_valid alone qualifies it,
  // so clearing it would only add reset fan-out to a wide datapath.
  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_rgb <= bus.rgb;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      color_q     <= 3'b000;
      exact_q     <= 1'b0;
    end else if (!stall) begin
      s1_valid    <= accept;
      out_valid_q <= s1_valid;
      color_q     <= s1_color;
      exact_q     <= s1_exact;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.color     = color_q;
  assign bus.exact     = exact_q;

`ifdef RGB_DEC_STATS_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts completed output handshakes of non-primary pixels; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && !exact_q && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign mismatch_cnt = cnt_q;
`else
  assign mismatch_cnt = '0;
`endif

endmodule
